// File: rtl/btpipe_block_source.sv
// btpipe_block_source: producer-to-okBTPipeOut block FIFO with level, block count and underflow status
// Ports:
//   okClk          sole clock, rising edge
//   rst            synchronous active-high reset
//   flush          synchronous FIFO clear (blk_count, underflow, ep_datain kept)
//   s_data/s_valid/s_ready   producer word stream
//   ep_datain      registered word to okBTPipeOut, valid the cycle after ep_read
//   ep_read        pop request from okBTPipeOut
//   ep_ready       a full block (BLOCK_WORDS) is buffered
//   ep_blockstrobe one-cycle pulse at each host block start
//   level          words currently buffered
//   blk_count      host blocks started since reset (wraps)
//   underflow      sticky, set by ep_read on an empty FIFO
//   testpat        (only with BTPIPE_SRC_TESTPAT_EN) push a running counter instead of s_data
module btpipe_block_source #(
    parameter int DEPTH       = 1024,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                       okClk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [31:0]                s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [31:0]                ep_datain,
    input  logic                       ep_read,
    output logic                       ep_ready,
    input  logic                       ep_blockstrobe,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                blk_count,
`ifdef BTPIPE_SRC_TESTPAT_EN
    input  logic                       testpat,
`endif
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] BLK  = LW'(BLOCK_WORDS);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          push, pop;
    logic [31:0]   wdata;

    // A full FIFO refuses the push even when a pop happens on the same edge.
    assign s_ready  = !rst && !flush && level < FULL;
    assign ep_ready = !rst && level >= BLK;
    assign push     = s_valid && s_ready;
    assign pop      = !rst && !flush && ep_read && level != '0;

`ifdef BTPIPE_SRC_TESTPAT_EN
    logic [31:0] pat_cnt;
    assign wdata = testpat ? pat_cnt : s_data;
    always_ff @(posedge okClk) begin
        if (rst || flush)
            pat_cnt <= '0;
        else if (push)
            pat_cnt <= pat_cnt + 32'd1;
    end
`else
    assign wdata = s_data;
`endif

    always_ff @(posedge okClk) begin
        if (push)
            mem[wp] <= wdata;
    end

    always_ff @(posedge okClk) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            ep_datain <= '0;
            blk_count <= '0;
            underflow <= 1'b0;
        end else begin
            if (ep_blockstrobe)
                blk_count <= blk_count + 16'd1;
            if (flush) begin
                wp    <= '0;
                rp    <= '0;
                level <= '0;
            end else begin
                if (push)
                    wp <= wp + AW'(1);
                if (pop) begin
                    rp        <= rp + AW'(1);
                    ep_datain <= mem[rp];
                end
                if (ep_read && level == '0)
                    underflow <= 1'b1;
                level <= level + LW'(push) - LW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_btpipe_block_source.sv
// tb_btpipe_block_source: randomized scoreboard bench for btpipe_block_source (DEPTH=16, BLOCK_WORDS=4)
module tb_btpipe_block_source;
    localparam int DEPTH = 16;
    localparam int BW    = 4;

    logic        okClk = 1'b0;
    logic        rst, flush, s_valid, ep_read, ep_blockstrobe, tp;
    logic [31:0] s_data;
    logic        s_ready, ep_ready, underflow;
    logic [31:0] ep_datain;
    logic [4:0]  level;
    logic [15:0] blk_count;

    btpipe_block_source #(.DEPTH(DEPTH), .BLOCK_WORDS(BW)) dut (
        .okClk(okClk), .rst(rst), .flush(flush), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .ep_datain(ep_datain), .ep_read(ep_read), .ep_ready(ep_ready),
        .ep_blockstrobe(ep_blockstrobe), .level(level), .blk_count(blk_count),
`ifdef BTPIPE_SRC_TESTPAT_EN
        .testpat(tp),
`endif
        .underflow(underflow)
    );

    always #5 okClk = ~okClk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_dout;
    logic [31:0] m_cnt;
    logic [15:0] m_blk;
    logic        m_und;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Monitor: each accepted pop presents a word on ep_datain one cycle later.
    always @(negedge okClk) begin
        if (exp_q.size() > 0)
            chk("sb_data", ep_datain, exp_q.pop_front());
    end

    task automatic step(input logic r, input logic f, input logic v, input logic rd,
                        input logic bs, input logic [31:0] d);
        logic push_ok, pop_ok;
        rst = r; flush = f; s_valid = v; ep_read = rd; ep_blockstrobe = bs; s_data = d;
        #1;
        push_ok = !r && !f && v && mq.size() < DEPTH;
        pop_ok  = !r && !f && rd && mq.size() > 0;
        chk("s_ready", s_ready, {31'd0, !r && !f && mq.size() < DEPTH});
        @(posedge okClk);
        if (r) begin
            mq.delete(); m_dout = 0; m_blk = 0; m_und = 0; m_cnt = 0;
        end else begin
            if (bs) m_blk = m_blk + 16'd1;
            if (f) begin
                mq.delete(); m_cnt = 0;
            end else begin
                if (rd && mq.size() == 0) m_und = 1;
                if (pop_ok) begin
                    m_dout = mq.pop_front();
                    exp_q.push_back(m_dout);
                end
                if (push_ok) begin
                    mq.push_back(tp ? m_cnt : d);
                    m_cnt = m_cnt + 1;
                end
            end
        end
        #1;
        chk("level", level, mq.size());
        chk("ep_ready", ep_ready, {31'd0, !r && mq.size() >= BW});
        chk("underflow", underflow, m_und);
        chk("blk_count", blk_count, m_blk);
        chk("ep_datain", ep_datain, m_dout);
        @(negedge okClk);
    endtask

    initial begin
        tp = 0; m_dout = 0; m_cnt = 0; m_blk = 0; m_und = 0;
        rst = 1; flush = 0; s_valid = 0; ep_read = 0; ep_blockstrobe = 0; s_data = 0;
        @(negedge okClk);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_level", level, 0);
        chk("rst_dout", ep_datain, 0);
        // three words: no block yet, fourth completes it
        step(0, 0, 1, 0, 0, 32'h11);
        step(0, 0, 1, 0, 0, 32'h22);
        step(0, 0, 1, 0, 0, 32'h33);
        chk("lvl3", level, 3);
        chk("not_ready3", ep_ready, 0);
        step(0, 0, 1, 0, 0, 32'h44);
        chk("ready4", ep_ready, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        chk("last_word", ep_datain, 32'h44);
        chk("drained", level, 0);
        // overfill by one, then pop with s_valid held
        for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 0, 32'h100 + i);
        chk("full", level, 16);
        step(0, 0, 1, 1, 0, 32'h200);
        chk("after_pop", level, 15);
        step(0, 0, 1, 0, 0, 32'h201);
        chk("refill", level, 16);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 0);
        // read on empty: sticky underflow, data held
        step(0, 0, 0, 1, 0, 0);
        chk("underflow_set", underflow, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("underflow_sticky", underflow, 1);
        // reset clears counters and underflow, then three strobes and flush at level 5
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0, 32'hA000 + i);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        chk("blk3", blk_count, 3);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, $urandom);
        step(0, 1, 1, 1, 0, 0);
        chk("flush_lvl", level, 0);
        chk("flush_blk", blk_count, 3);
        // randomized traffic including occasional flush/reset
        for (int i = 0; i < 600; i++) begin
`ifdef BTPIPE_SRC_TESTPAT_EN
            tp = ($urandom_range(0, 3) == 0);
`endif
            step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom);
        end
        tp = 0;
        step(0, 0, 0, 0, 0, 0);
        chk("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
